// File: rtl/pmem_arbiter.sv
// Arbitrates the single burst physical-memory port between the icache (read-only)
// and the dcache (read/write), one cache-line transaction at a time, round-robin on contention.
module pmem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  i_pmem_read,
    input  logic [ADDR_WIDTH-1:0] i_pmem_address,
    output logic [LINE_WIDTH-1:0] i_pmem_rdata,
    output logic                  i_pmem_resp,

    input  logic                  d_pmem_read,
    input  logic                  d_pmem_write,
    input  logic [ADDR_WIDTH-1:0] d_pmem_address,
    input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
    output logic [LINE_WIDTH-1:0] d_pmem_rdata,
    output logic                  d_pmem_resp,

    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp,

    output logic [31:0]           i_grant_count,
    output logic [31:0]           d_grant_count
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SERVE_I = 2'd1;
    localparam logic [1:0] ST_SERVE_D = 2'd2;

    localparam logic LAST_I = 1'b0;
    localparam logic LAST_D = 1'b1;

    logic [1:0]            state_q,         state_d;
    logic                  last_served_q,   last_served_d;
    logic [ADDR_WIDTH-1:0] addr_q,          addr_d;
    logic [LINE_WIDTH-1:0] wdata_q,         wdata_d;
    logic                  op_write_q,      op_write_d;
    logic [31:0]           i_grant_count_q, i_grant_count_d;
    logic [31:0]           d_grant_count_q, d_grant_count_d;

    logic i_req;
    logic d_req;
    logic busy;

    assign i_req = i_pmem_read;
    assign d_req = d_pmem_read | d_pmem_write;

    always_comb begin
        state_d         = state_q;
        last_served_d   = last_served_q;
        addr_d          = addr_q;
        wdata_d         = wdata_q;
        op_write_d      = op_write_q;
        i_grant_count_d = i_grant_count_q;
        d_grant_count_d = d_grant_count_q;

        case (state_q)
            ST_IDLE: begin
                // On contention the side not served last wins, so dcache goes first after reset.
                if (d_req && (!i_req || last_served_q == LAST_I)) begin
                    state_d    = ST_SERVE_D;
                    addr_d     = d_pmem_address;
                    wdata_d    = d_pmem_wdata;
                    op_write_d = d_pmem_write;
                end else if (i_req) begin
                    state_d    = ST_SERVE_I;
                    addr_d     = i_pmem_address;
                    wdata_d    = '0;
                    op_write_d = 1'b0;
                end
            end
            ST_SERVE_I: begin
                if (pmem_resp) begin
                    state_d         = ST_IDLE;
                    last_served_d   = LAST_I;
                    i_grant_count_d = i_grant_count_q + 32'd1;
                end
            end
            ST_SERVE_D: begin
                if (pmem_resp) begin
                    state_d         = ST_IDLE;
                    last_served_d   = LAST_D;
                    d_grant_count_d = d_grant_count_q + 32'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            last_served_q   <= LAST_I;
            addr_q          <= '0;
            wdata_q         <= '0;
            op_write_q      <= 1'b0;
            i_grant_count_q <= '0;
            d_grant_count_q <= '0;
        end else begin
            state_q         <= state_d;
            last_served_q   <= last_served_d;
            addr_q          <= addr_d;
            wdata_q         <= wdata_d;
            op_write_q      <= op_write_d;
            i_grant_count_q <= i_grant_count_d;
            d_grant_count_q <= d_grant_count_d;
        end
    end

    // Strobes are gated by rst so nothing reaches the adaptor or caches while reset is held.
    assign busy = (state_q == ST_SERVE_I) || (state_q == ST_SERVE_D);

    assign pmem_read    = ~rst & busy & ~op_write_q;
    assign pmem_write   = ~rst & busy &  op_write_q;
    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;

    assign i_pmem_resp  = ~rst & pmem_resp & (state_q == ST_SERVE_I);
    assign d_pmem_resp  = ~rst & pmem_resp & (state_q == ST_SERVE_D);

    assign i_pmem_rdata = pmem_rdata;
    assign d_pmem_rdata = pmem_rdata;

    assign i_grant_count = i_grant_count_q;
    assign d_grant_count = d_grant_count_q;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed bench for pmem_arbiter: vector table for single/contended grants, then
// hand sequences for alternation, address latching, mid-burst reset and counter wrap.
module tb_pmem_arbiter;

    logic         clk;
    logic         rst;
    logic         i_pmem_read;
    logic [31:0]  i_pmem_address;
    logic [255:0] i_pmem_rdata;
    logic         i_pmem_resp;
    logic         d_pmem_read;
    logic         d_pmem_write;
    logic [31:0]  d_pmem_address;
    logic [255:0] d_pmem_wdata;
    logic [255:0] d_pmem_rdata;
    logic         d_pmem_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;
    logic [31:0]  i_grant_count;
    logic [31:0]  d_grant_count;

    int n_cmp;
    int n_bad;

    pmem_arbiter #(.ADDR_WIDTH(32), .LINE_WIDTH(256)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_pmem_read    (i_pmem_read),
        .i_pmem_address (i_pmem_address),
        .i_pmem_rdata   (i_pmem_rdata),
        .i_pmem_resp    (i_pmem_resp),
        .d_pmem_read    (d_pmem_read),
        .d_pmem_write   (d_pmem_write),
        .d_pmem_address (d_pmem_address),
        .d_pmem_wdata   (d_pmem_wdata),
        .d_pmem_rdata   (d_pmem_rdata),
        .d_pmem_resp    (d_pmem_resp),
        .pmem_read      (pmem_read),
        .pmem_write     (pmem_write),
        .pmem_address   (pmem_address),
        .pmem_wdata     (pmem_wdata),
        .pmem_rdata     (pmem_rdata),
        .pmem_resp      (pmem_resp),
        .i_grant_count  (i_grant_count),
        .d_grant_count  (d_grant_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
        $fatal(1);
    end

    typedef struct {
        logic        rst;
        logic        i_rd;
        logic [31:0] i_addr;
        logic        d_rd;
        logic        d_wr;
        logic [31:0] d_addr;
        logic [31:0] d_wd;
        logic        resp;
        logic [31:0] rdata;
        logic        e_rd;
        logic        e_wr;
        logic [31:0] e_addr;
        logic [31:0] e_wd;
        logic        e_iresp;
        logic        e_dresp;
        logic [31:0] e_icnt;
        logic [31:0] e_dcnt;
    } vec_t;

    vec_t vecs[14];

    function automatic vec_t mk(
        input logic r, input logic ird, input logic [31:0] ia,
        input logic drd, input logic dwr, input logic [31:0] da, input logic [31:0] dwd,
        input logic rsp, input logic [31:0] rd,
        input logic erd, input logic ewr, input logic [31:0] ea, input logic [31:0] ewd,
        input logic eir, input logic edr, input logic [31:0] eic, input logic [31:0] edc);
        vec_t v;
        v.rst = r;     v.i_rd = ird;  v.i_addr = ia;
        v.d_rd = drd;  v.d_wr = dwr;  v.d_addr = da;  v.d_wd = dwd;
        v.resp = rsp;  v.rdata = rd;
        v.e_rd = erd;  v.e_wr = ewr;  v.e_addr = ea;  v.e_wd = ewd;
        v.e_iresp = eir; v.e_dresp = edr; v.e_icnt = eic; v.e_dcnt = edc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_pmem_read    = 1'b0;
        i_pmem_address = '0;
        d_pmem_read    = 1'b0;
        d_pmem_write   = 1'b0;
        d_pmem_address = '0;
        d_pmem_wdata   = '0;
        pmem_resp      = 1'b0;
        pmem_rdata     = '0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        clear_inputs();

        //            rst ird iaddr   drd dwr daddr    dwd     rsp rdata   | erd ewr eaddr    ewd    eir edr icnt dcnt
        vecs[0]  = mk(1, 0, 32'h0,    0, 0, 32'h0,   32'h0,  0, 32'h0,      0, 0, 32'h0,   32'h0,  0, 0, 0, 0);
        vecs[1]  = mk(1, 0, 32'h0,    0, 0, 32'h0,   32'h0,  0, 32'h0,      0, 0, 32'h0,   32'h0,  0, 0, 0, 0);
        vecs[2]  = mk(0, 1, 32'h60,   0, 0, 32'h0,   32'h0,  0, 32'h0,      0, 0, 32'h0,   32'h0,  0, 0, 0, 0);
        vecs[3]  = mk(0, 1, 32'h60,   0, 0, 32'h0,   32'h0,  0, 32'h0,      1, 0, 32'h60,  32'h0,  0, 0, 0, 0);
        vecs[4]  = mk(0, 1, 32'h60,   0, 0, 32'h0,   32'h0,  1, 32'hAAAA,   1, 0, 32'h60,  32'h0,  1, 0, 0, 0);
        vecs[5]  = mk(0, 0, 32'h0,    0, 0, 32'h0,   32'h0,  0, 32'h0,      0, 0, 32'h0,   32'h0,  0, 0, 1, 0);
        vecs[6]  = mk(1, 1, 32'h80,   0, 1, 32'h100, 32'h55, 0, 32'h0,      0, 0, 32'h0,   32'h0,  0, 0, 1, 0);
        vecs[7]  = mk(0, 1, 32'h80,   0, 1, 32'h100, 32'h55, 0, 32'h0,      0, 0, 32'h0,   32'h0,  0, 0, 0, 0);
        vecs[8]  = mk(0, 1, 32'h80,   0, 1, 32'h100, 32'h55, 0, 32'h0,      0, 1, 32'h100, 32'h55, 0, 0, 0, 0);
        vecs[9]  = mk(0, 1, 32'h80,   0, 1, 32'h300, 32'h77, 1, 32'hBBBB,   0, 1, 32'h100, 32'h55, 0, 1, 0, 0);
        vecs[10] = mk(0, 1, 32'h80,   0, 0, 32'h0,   32'h0,  0, 32'h0,      0, 0, 32'h0,   32'h0,  0, 0, 0, 1);
        vecs[11] = mk(0, 1, 32'h80,   0, 0, 32'h0,   32'h0,  0, 32'h0,      1, 0, 32'h80,  32'h0,  0, 0, 0, 1);
        vecs[12] = mk(0, 1, 32'h80,   0, 0, 32'h0,   32'h0,  1, 32'hCCCC,   1, 0, 32'h80,  32'h0,  1, 0, 0, 1);
        vecs[13] = mk(0, 0, 32'h0,    0, 0, 32'h0,   32'h0,  0, 32'h0,      0, 0, 32'h0,   32'h0,  0, 0, 1, 1);

        step();
        for (int k = 0; k < 14; k++) begin
            rst            = vecs[k].rst;
            i_pmem_read    = vecs[k].i_rd;
            i_pmem_address = vecs[k].i_addr;
            d_pmem_read    = vecs[k].d_rd;
            d_pmem_write   = vecs[k].d_wr;
            d_pmem_address = vecs[k].d_addr;
            d_pmem_wdata   = {224'h0, vecs[k].d_wd};
            pmem_resp      = vecs[k].resp;
            pmem_rdata     = {224'h0, vecs[k].rdata};
            @(negedge clk);
            chk($sformatf("v%0d pmem_read", k),   pmem_read,     vecs[k].e_rd);
            chk($sformatf("v%0d pmem_write", k),  pmem_write,    vecs[k].e_wr);
            chk($sformatf("v%0d i_resp", k),      i_pmem_resp,   vecs[k].e_iresp);
            chk($sformatf("v%0d d_resp", k),      d_pmem_resp,   vecs[k].e_dresp);
            chk($sformatf("v%0d i_count", k),     i_grant_count, vecs[k].e_icnt);
            chk($sformatf("v%0d d_count", k),     d_grant_count, vecs[k].e_dcnt);
            if (vecs[k].e_rd || vecs[k].e_wr) begin
                chk($sformatf("v%0d address", k), pmem_address, vecs[k].e_addr);
                chk($sformatf("v%0d wdata", k),   pmem_wdata,   {224'h0, vecs[k].e_wd});
            end
            if (vecs[k].resp) begin
                chk($sformatf("v%0d i_rdata", k), i_pmem_rdata, {224'h0, vecs[k].rdata});
                chk($sformatf("v%0d d_rdata", k), d_pmem_rdata, {224'h0, vecs[k].rdata});
            end
            step();
        end

        // Continuous contention: last served was icache, so expect D,I,D,I,D,I.
        clear_inputs();
        i_pmem_read    = 1'b1;
        i_pmem_address = 32'h400;
        d_pmem_read    = 1'b1;
        d_pmem_address = 32'h500;
        for (int t = 0; t < 6; t++) begin
            logic exp_d;
            exp_d = (t % 2 == 0);
            @(negedge clk);
            chk($sformatf("alt%0d idle bubble", t), {pmem_read, pmem_write}, 2'b00);
            step();
            @(negedge clk);
            chk($sformatf("alt%0d pmem_read", t), pmem_read, 1'b1);
            chk($sformatf("alt%0d address", t), pmem_address, exp_d ? 32'h500 : 32'h400);
            step();
            pmem_resp = 1'b1;
            @(negedge clk);
            chk($sformatf("alt%0d resp pair", t), {i_pmem_resp, d_pmem_resp}, exp_d ? 2'b01 : 2'b10);
            step();
            pmem_resp = 1'b0;
        end
        @(negedge clk);
        chk("alt i_count", i_grant_count, 32'd4);
        chk("alt d_count", d_grant_count, 32'd4);

        // Address latched at grant survives a mid-burst address change.
        clear_inputs();
        d_pmem_read    = 1'b1;
        d_pmem_address = 32'h200;
        step();
        d_pmem_address = 32'h300;
        @(negedge clk);
        chk("latch addr c1", pmem_address, 32'h200);
        step();
        @(negedge clk);
        chk("latch addr c2", pmem_address, 32'h200);
        step();
        pmem_resp = 1'b1;
        @(negedge clk);
        chk("latch addr resp", pmem_address, 32'h200);
        chk("latch d_resp", d_pmem_resp, 1'b1);
        step();
        clear_inputs();
        @(negedge clk);
        chk("latch d_count", d_grant_count, 32'd5);

        // Reset two cycles into SERVE_D abandons the burst.
        d_pmem_read    = 1'b1;
        d_pmem_address = 32'h200;
        step();
        step();
        @(negedge clk);
        chk("rst pre pmem_read", pmem_read, 1'b1);
        step();
        rst         = 1'b1;
        pmem_resp   = 1'b1;
        d_pmem_read = 1'b0;
        @(negedge clk);
        chk("rst d_resp held", d_pmem_resp, 1'b0);
        step();
        rst       = 1'b0;
        pmem_resp = 1'b0;
        @(negedge clk);
        chk("rst strobes", {pmem_read, pmem_write}, 2'b00);
        chk("rst i_count", i_grant_count, 32'd0);
        chk("rst d_count", d_grant_count, 32'd0);
        chk("rst d_resp", d_pmem_resp, 1'b0);
        step();
        @(negedge clk);
        chk("rst stays idle", {pmem_read, pmem_write}, 2'b00);

        // Counter wrap from 0xFFFFFFFF.
        force dut.d_grant_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.d_grant_count_q;
        @(negedge clk);
        chk("wrap preload", d_grant_count, 32'hFFFF_FFFF);
        step();
        d_pmem_read    = 1'b1;
        d_pmem_address = 32'h240;
        step();
        pmem_resp = 1'b1;
        @(negedge clk);
        chk("wrap d_resp", d_pmem_resp, 1'b1);
        step();
        clear_inputs();
        @(negedge clk);
        chk("wrap d_count", d_grant_count, 32'd0);
        chk("wrap i_count", i_grant_count, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
